// File: rtl/key_debounce.sv
// key_debounce: per-key 2-flop synchronizer, debounce counter and 4-state FSM
// producing a debounced level plus one-cycle press / release / long-press pulses.
// Optional build macro: KEY_REPEAT_EN -- KEY_LONG_o auto-repeats every RPT_CYC
// cycles after the first long-press pulse while the key stays held.
`timescale 1ns/1ps

module key_debounce_lane #(
  parameter int CW       = 8,
  parameter int DB_CYC   = 20,
  parameter int LONG_CYC = 100
`ifdef KEY_REPEAT_EN
  , parameter int RPT_CYC = 50
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic level_o,
  output logic press_o,
  output logic rel_o,
  output logic long_o
);

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} st_t;

  localparam logic [CW-1:0] DB_M1   = CW'(DB_CYC - 1);
  localparam logic [CW-1:0] LONG_M1 = CW'(LONG_CYC - 1);
  // Long pulse is registered, so it is armed one count early.
  localparam logic [CW-1:0] LONG_M2 = CW'(LONG_CYC - 2);
`ifdef KEY_REPEAT_EN
  localparam logic [CW-1:0] RPT_M1  = CW'(RPT_CYC - 1);
`endif

  st_t           state_q, state_d;
  logic          s1_q, s2_q;
  logic          p;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] hold_q, hold_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          rel_q, rel_d;
  logic          long_q, long_d;
`ifdef KEY_REPEAT_EN
  logic          rpt_q, rpt_d;
`endif

  // Two-flop synchronizer; resets to the released (high) pin level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
    end else begin
      s1_q <= key_n;
      s2_q <= s1_q;
    end
  end

  assign p = ~s2_q;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic. ">=" keeps DB_CYC==1 from stalling in the wait states.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:         if (p) state_d = PRESS_WAIT;
      PRESS_WAIT:   if (!p) state_d = IDLE;
                    else if (cnt_q >= DB_M1) state_d = PRESSED;
      PRESSED:      if (!p) state_d = RELEASE_WAIT;
      RELEASE_WAIT: if (p) state_d = PRESSED;
                    else if (cnt_q >= DB_M1) state_d = IDLE;
      default:      state_d = IDLE;
    endcase
  end

  // Counters and registered event outputs, decided from the current state.
  always_comb begin
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    level_d = level_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    long_d  = 1'b0;
`ifdef KEY_REPEAT_EN
    rpt_d   = rpt_q;
`endif
    case (state_q)
      IDLE: cnt_d = p ? CW'(1) : '0;
      PRESS_WAIT: begin
        if (!p) cnt_d = '0;
        else if (cnt_q >= DB_M1) begin
          cnt_d   = '0;
          hold_d  = '0;
          level_d = 1'b1;
          press_d = 1'b1;
`ifdef KEY_REPEAT_EN
          rpt_d   = 1'b0;
`endif
        end else cnt_d = cnt_q + 1'b1;
      end
      PRESSED: begin
        if (!p) cnt_d = CW'(1);
        else begin
`ifdef KEY_REPEAT_EN
          // First period is LONG_CYC, then hold reloads and runs RPT_CYC.
          if (!rpt_q) begin
            if (hold_q == LONG_M2) begin
              long_d = 1'b1;
              hold_d = '0;
              rpt_d  = 1'b1;
            end else hold_d = hold_q + 1'b1;
          end else begin
            if (hold_q >= RPT_M1) begin
              long_d = 1'b1;
              hold_d = '0;
            end else hold_d = hold_q + 1'b1;
          end
`else
          // Saturating hold: a single long pulse per press.
          if (hold_q < LONG_M1) begin
            hold_d = hold_q + 1'b1;
            if (hold_q == LONG_M2) long_d = 1'b1;
          end
`endif
        end
      end
      RELEASE_WAIT: begin
        if (p) cnt_d = '0;
        else if (cnt_q >= DB_M1) begin
          cnt_d   = '0;
          level_d = 1'b0;
          rel_d   = 1'b1;
        end else cnt_d = cnt_q + 1'b1;
      end
      default: cnt_d = '0;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      hold_q  <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      long_q  <= 1'b0;
`ifdef KEY_REPEAT_EN
      rpt_q   <= 1'b0;
`endif
    end else begin
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      long_q  <= long_d;
`ifdef KEY_REPEAT_EN
      rpt_q   <= rpt_d;
`endif
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;
  assign rel_o   = rel_q;
  assign long_o  = long_q;

endmodule

module key_debounce #(
  parameter int CLK_FREQ    = 300_000_000,
  parameter int KEY_NUM     = 4,
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 1000,
  parameter int REPEAT_MS   = 200
) (
  input  logic               CLK_i,
  input  logic               RSTn_i,
  input  logic [KEY_NUM-1:0] KEY_i,
  output logic [KEY_NUM-1:0] KEY_LEVEL_o,
  output logic [KEY_NUM-1:0] KEY_PRESS_o,
  output logic [KEY_NUM-1:0] KEY_RELEASE_o,
  output logic [KEY_NUM-1:0] KEY_LONG_o
);

  localparam int CYC_MS   = CLK_FREQ / 1000;
  localparam int DB_CYC   = CYC_MS * DEBOUNCE_MS;
  localparam int LONG_CYC = CYC_MS * LONG_MS;
  localparam int RPT_CYC  = CYC_MS * REPEAT_MS;
  // RPT_CYC is folded in so both builds share one counter width; it is
  // normally below LONG_CYC and then changes nothing.
  localparam int MAX_A    = (LONG_CYC > DB_CYC) ? LONG_CYC : DB_CYC;
  localparam int MAX_CYC  = (RPT_CYC > MAX_A) ? RPT_CYC : MAX_A;
  localparam int CW       = $clog2(MAX_CYC) + 1;

  // One independent debounce lane per key.
  for (genvar i = 0; i < KEY_NUM; i++) begin : g_key
    key_debounce_lane #(
      .CW       (CW),
      .DB_CYC   (DB_CYC),
      .LONG_CYC (LONG_CYC)
`ifdef KEY_REPEAT_EN
      , .RPT_CYC (RPT_CYC)
`endif
    ) u_lane (
      .clk     (CLK_i),
      .rst_n   (RSTn_i),
      .key_n   (KEY_i[i]),
      .level_o (KEY_LEVEL_o[i]),
      .press_o (KEY_PRESS_o[i]),
      .rel_o   (KEY_RELEASE_o[i]),
      .long_o  (KEY_LONG_o[i])
    );
  end

endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: scoreboard bench for key_debounce (DB_CYC=20, LONG_CYC=100,
// RPT_CYC=50). Expected events are queued when keys are driven and retired by
// a negedge monitor as the DUT pulses.
`timescale 1ns/1ps

module tb_key_debounce;

  logic       clk;
  logic       rst_n;
  logic [3:0] key;
  logic [3:0] lvl, prs, rel, lng;

  key_debounce #(
    .CLK_FREQ(10_000), .KEY_NUM(4), .DEBOUNCE_MS(2), .LONG_MS(10), .REPEAT_MS(5)
  ) dut (
    .CLK_i(clk), .RSTn_i(rst_n), .KEY_i(key),
    .KEY_LEVEL_o(lvl), .KEY_PRESS_o(prs), .KEY_RELEASE_o(rel), .KEY_LONG_o(lng)
  );

  typedef struct {int kind; int key; int lo; int hi;} exp_t;  // kind 0 press 1 rel 2 long
  exp_t sb[$];

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int kind, input int k, input int lo, input int hi);
    exp_t e;
    e.kind = kind; e.key = k; e.lo = lo; e.hi = hi;
    sb.push_back(e);
  endtask

  task automatic wait_bit(input int kind, input int b, input int max, output int at);
    logic [3:0] v;
    at = -1;
    for (int i = 0; i < max && at < 0; i++) begin
      @(negedge clk);
      v = (kind == 0) ? prs : (kind == 1) ? rel : lng;
      if (v[b]) at = cyc;
    end
    if (at < 0) chk($sformatf("timeout k%0d b%0d", kind, b), 0, 1);
  endtask

  // Monitor: every asserted event bit retires the oldest expectation.
  logic [3:0] mon_v;
  exp_t       mon_e;
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      mon_v = (k == 0) ? prs : (k == 1) ? rel : lng;
      for (int b = 0; b < 4; b++) begin
        if (mon_v[b]) begin
          if (sb.size() == 0) chk($sformatf("spurious k%0d b%0d c%0d", k, b, cyc), 1, 0);
          else begin
            mon_e = sb.pop_front();
            chk($sformatf("ev_id c%0d", cyc), k * 16 + b, mon_e.kind * 16 + mon_e.key);
            chk($sformatf("ev_lat k%0d b%0d c%0d win %0d..%0d", k, b, cyc, mon_e.lo, mon_e.hi),
                int'(cyc >= mon_e.lo && cyc <= mon_e.hi), 1);
          end
        end
      end
    end
  end

  initial begin
    int d, at, p;
    rst_n = 1'b0;
    key   = 4'hF;
    tick(3);
    chk("rst_level", lvl, 0);
    chk("rst_press", prs, 0);
    chk("rst_rel",   rel, 0);
    chk("rst_long",  lng, 0);
    rst_n = 1'b1;
    tick(200);
    chk("idle_quiet", lvl | prs | rel | lng, 0);

    // clean press / release on key 0
    key[0] = 1'b0; d = cyc;
    push(0, 0, d + 21, d + 23);
    wait_bit(0, 0, 40, at);
    chk("lvl_at_press", lvl[0], 1);
    tick(50);
    key[0] = 1'b1; d = cyc;
    push(1, 0, d + 21, d + 23);
    wait_bit(1, 0, 40, at);
    chk("lvl_at_rel", lvl[0], 0);
    tick(30);

    // bouncing key 1: 5-cycle segments must be ignored
    for (int i = 0; i < 12; i++) begin
      key[1] = (i % 2 == 0) ? 1'b0 : 1'b1;
      tick(5);
    end
    chk("bounce_lvl", lvl[1], 0);
    key[1] = 1'b0; d = cyc;
    push(0, 1, d + 21, d + 23);
    wait_bit(0, 1, 40, at);
    tick(40);
    key[1] = 1'b1; d = cyc;
    push(1, 1, d + 21, d + 23);
    wait_bit(1, 1, 40, at);
    tick(30);

    // long press on key 2
    key[2] = 1'b0; d = cyc;
    push(0, 2, d + 21, d + 23);
    wait_bit(0, 2, 40, p);
    push(2, 2, p + 99, p + 99);
`ifdef KEY_REPEAT_EN
    push(2, 2, p + 149, p + 149);
`endif
    tick(d + 200 - cyc);
    chk("long_lvl_held", lvl[2], 1);
    key[2] = 1'b1; d = cyc;
    push(1, 2, d + 21, d + 23);
    wait_bit(1, 2, 60, at);
    tick(30);

    // reset in the middle of a key-3 press
    key[3] = 1'b0;
    tick(10);
    rst_n = 1'b0;
    tick(3);
    chk("midrst_level", lvl, 0);
    rst_n = 1'b1; d = cyc;
    push(0, 3, d + 21, d + 23);
    wait_bit(0, 3, 40, at);
    tick(20);
    key[3] = 1'b1; d = cyc;
    push(1, 3, d + 21, d + 23);
    wait_bit(1, 3, 40, at);
    tick(30);

    // simultaneous keys 0 and 3
    key[0] = 1'b0; key[3] = 1'b0; d = cyc;
    push(0, 0, d + 21, d + 23);
    push(0, 3, d + 21, d + 23);
    wait_bit(0, 0, 40, at);
    chk("simul_press", prs, 4'b1001);
    tick(30);
    key[0] = 1'b1; key[3] = 1'b1; d = cyc;
    push(1, 0, d + 21, d + 23);
    push(1, 3, d + 21, d + 23);
    wait_bit(1, 0, 40, at);
    chk("simul_rel", rel, 4'b1001);
    tick(30);

    chk("sb_empty", sb.size(), 0);
    chk("final_level", lvl, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
